instruction_fetch: RTL and testbench

- Instruction-fetch stage; sits directly upstream of the IF/ID pipeline register and drives its IF_instruction / IF_pcplus4 inputs.
- Owns the PC and issues word fetches to instruction memory through a req/ready + rvalid interface.
- Buffers returned words in a small in-order queue.
- Handles hazard-unit stalls and branch/jump redirects, discarding stale in-flight responses.

---
 rtl/instruction_fetch.sv | 83 ++++++++
 tb/tb_instruction_fetch.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// instruction_fetch: PC owner issuing credit-limited imem fetches into an in-order queue feeding IF/ID, with stall and redirect flush
module instruction_fetch #(
  parameter int QDEPTH = 2,
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] IF_instruction,
  output logic [31:0] IF_pcplus4,
  output logic        IF_valid
);
  localparam int CW = $clog2(QDEPTH + 1);
  localparam int AW = QDEPTH > 1 ? $clog2(QDEPTH) : 1;
  logic [31:0] pc, resp_pc, tgt;
  logic [31:0] q_ins [QDEPTH];
  logic [31:0] q_pc [QDEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] cnt, o, d;
  logic accept, discard, push, pop;
  assign imem_req = !redirect_valid && (({1'b0, o} + {1'b0, cnt}) < (CW + 1)'(QDEPTH));
  assign imem_addr = pc;
  assign accept = imem_req && imem_ready;
  assign discard = imem_rvalid && (d != '0 || redirect_valid);
  assign push = imem_rvalid && !discard;
  assign pop = !redirect_valid && !stall && cnt != '0;
  assign tgt = redirect_target & ~32'd3;
  always_ff @(posedge clk) begin
    if (push) begin
      q_ins[wr] <= imem_rdata;
      q_pc[wr] <= resp_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
      resp_pc <= RESET_PC;
      rd <= '0;
      wr <= '0;
      cnt <= '0;
      o <= '0;
      d <= '0;
      IF_instruction <= NOP_INSTR;
      IF_pcplus4 <= '0;
      IF_valid <= 1'b0;
    end else begin
      o <= o + CW'(accept) - CW'(imem_rvalid);
      if (redirect_valid) begin
        pc <= tgt;
        resp_pc <= tgt;
        rd <= '0;
        wr <= '0;
        cnt <= '0;
        d <= o - CW'(imem_rvalid);
        IF_instruction <= NOP_INSTR;
        IF_pcplus4 <= '0;
        IF_valid <= 1'b0;
      end else begin
        if (accept) pc <= pc + 32'd4;
        if (push) begin
          resp_pc <= resp_pc + 32'd4;
          wr <= wr == AW'(QDEPTH - 1) ? '0 : wr + 1'b1;
        end
        if (pop) rd <= rd == AW'(QDEPTH - 1) ? '0 : rd + 1'b1;
        d <= d - CW'(discard);
        cnt <= cnt + CW'(push) - CW'(pop);
        if (!stall) begin
          IF_instruction <= pop ? q_ins[rd] : NOP_INSTR;
          IF_valid <= pop;
          if (pop) IF_pcplus4 <= q_pc[rd] + 32'd4;
        end
      end
    end
  end
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: directed stimulus table against a queue-based reference of the fetch stage plus literal pins
module tb_instruction_fetch;
  localparam logic [31:0] NOP = 32'h0000_0013;
  logic clk = 1'b0;
  logic rst, stall, redirect_valid, imem_req, imem_ready, imem_rvalid, IF_valid;
  logic [31:0] redirect_target, imem_addr, imem_rdata, IF_instruction, IF_pcplus4;
  always #5 clk = ~clk;
  instruction_fetch dut (
    .clk(clk), .rst(rst), .stall(stall), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .IF_instruction(IF_instruction), .IF_pcplus4(IF_pcplus4), .IF_valid(IF_valid)
  );
  typedef struct {logic [31:0] a; bit s;} oe_t;
  typedef struct {logic [31:0] a; logic [31:0] d;} fe_t;
  typedef struct {int n; bit r; bit s; bit rv; logic [31:0] t; bit rdy; bit h; bit pin; logic [31:0] base;} st_t;
  st_t tbl [16] = '{
    '{2, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0},
    '{8, 0, 0, 0, 32'h0,         1, 0, 1, 32'h0},
    '{3, 0, 1, 0, 32'h0,         1, 0, 0, 32'h0},
    '{6, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0},
    '{4, 0, 0, 0, 32'h0,         1, 1, 0, 32'h0},
    '{1, 0, 0, 1, 32'h100,       1, 1, 0, 32'h0},
    '{8, 0, 0, 0, 32'h0,         1, 0, 1, 32'h100},
    '{4, 0, 0, 0, 32'h0,         1, 1, 0, 32'h0},
    '{1, 0, 0, 1, 32'h200,       1, 0, 0, 32'h0},
    '{8, 0, 0, 0, 32'h0,         1, 0, 1, 32'h200},
    '{5, 0, 0, 0, 32'h0,         0, 0, 0, 32'h0},
    '{6, 0, 0, 0, 32'h0,         1, 0, 0, 32'h0},
    '{1, 0, 0, 1, 32'hFFFF_FFFE, 1, 0, 0, 32'h0},
    '{8, 0, 0, 0, 32'h0,         1, 0, 1, 32'hFFFF_FFFC},
    '{1, 1, 0, 0, 32'h0,         1, 0, 0, 32'h0},
    '{6, 0, 0, 0, 32'h0,         1, 0, 1, 32'h0}
  };
  int checks = 0, errors = 0;
  bit m_ok = 0;
  logic [31:0] m_pc, m_ins, m_p4;
  logic m_v;
  oe_t oq[$];
  fe_t fq[$];
  logic [31:0] mem_q[$];
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", n, a, e);
    end
  endtask
  task automatic cycle(input st_t st);
    bit acc, keep, req_e;
    logic [31:0] acc_a;
    oe_t e;
    fe_t f, h;
    rst = st.r;
    stall = st.s;
    redirect_valid = st.rv;
    redirect_target = st.t;
    imem_ready = st.rdy;
    imem_rvalid = !st.h && !st.r && mem_q.size() > 0;
    imem_rdata = imem_rvalid ? mem_q[0] : 32'h0;
    @(negedge clk);
    acc = imem_req === 1'b1 && imem_ready;
    acc_a = imem_addr;
    if (m_ok && !st.r) begin
      req_e = !st.rv && (oq.size() + fq.size() < 2);
      chk("imem_req", {31'b0, imem_req}, {31'b0, req_e});
      chk("imem_addr", imem_addr, m_pc);
      keep = 0;
      if (imem_rvalid) begin
        if (oq.size() > 0) begin
          e = oq.pop_front();
          keep = !e.s && !st.rv;
          f.a = e.a;
          f.d = e.a;
        end else begin
          checks++;
          errors++;
          $display("FAIL rvalid_order: response with no request outstanding");
        end
      end
      if (st.rv) begin
        m_ins = NOP;
        m_v = 0;
        m_p4 = 0;
      end else if (!st.s) begin
        if (fq.size() > 0) begin
          h = fq.pop_front();
          m_ins = h.d;
          m_p4 = h.a + 32'd4;
          m_v = 1;
        end else begin
          m_ins = NOP;
          m_v = 0;
        end
      end
      if (keep) fq.push_back(f);
      if (st.rv) begin
        fq.delete();
        foreach (oq[i]) oq[i].s = 1;
        m_pc = st.t & ~32'd3;
      end else if (req_e && st.rdy) begin
        oq.push_back('{m_pc, 1'b0});
        m_pc = m_pc + 32'd4;
      end
    end
    if (st.r) begin
      m_ok = 1;
      m_pc = 32'h0;
      m_ins = NOP;
      m_p4 = 32'h0;
      m_v = 0;
      oq.delete();
      fq.delete();
    end
    @(posedge clk);
    #1;
    if (st.r) mem_q.delete();
    else begin
      if (imem_rvalid) void'(mem_q.pop_front());
      if (acc) mem_q.push_back(acc_a);
    end
    if (m_ok) begin
      chk("IF_instruction", IF_instruction, m_ins);
      chk("IF_pcplus4", IF_pcplus4, m_p4);
      chk("IF_valid", {31'b0, IF_valid}, {31'b0, m_v});
    end
  endtask
  initial begin
    int nv;
    rst = 1;
    stall = 0;
    redirect_valid = 0;
    redirect_target = 0;
    imem_ready = 1;
    imem_rvalid = 0;
    imem_rdata = 0;
    for (int s = 0; s < 16; s++) begin
      nv = 0;
      for (int c = 0; c < tbl[s].n; c++) begin
        cycle(tbl[s]);
        if (tbl[s].pin && IF_valid === 1'b1 && nv < 2) begin
          chk("pin_ins", IF_instruction, tbl[s].base + 32'(4 * nv));
          chk("pin_p4", IF_pcplus4, tbl[s].base + 32'(4 * nv + 4));
          nv++;
        end
      end
      if (tbl[s].pin) chk("pin_count", 32'(nv), 32'd2);
      if (tbl[s].r || tbl[s].rv) begin
        chk("flush_ins", IF_instruction, NOP);
        chk("flush_valid", {31'b0, IF_valid}, 32'd0);
      end
      if (tbl[s].r) begin
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_p4", IF_pcplus4, 32'h0);
      end
      if (tbl[s].rv) chk("redir_addr", imem_addr, tbl[s].t & ~32'd3);
      if (!tbl[s].rdy) begin
        chk("drain_ins", IF_instruction, NOP);
        chk("drain_valid", {31'b0, IF_valid}, 32'd0);
      end
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
